// File: rtl/one_hot_pkg.sv
// rtl/one_hot_pkg.sv - one-hot select helpers shared by mux, demux and arbiter blocks
//
// Contents:
//   MAX_CH          widest one-hot vector the helpers accept
//   MAX_IDX_W       index width for a MAX_CH-wide vector
//   is_one_hot      1 when exactly one bit of the vector is set
//   one_hot_to_idx  binary index of the set bit (OR of indices of set bits)

package one_hot_pkg;

    localparam int MAX_CH    = 32;
    localparam int MAX_IDX_W = 5;

    // Callers zero-extend narrower selects to MAX_CH bits before calling.
    function automatic logic is_one_hot(input logic [MAX_CH-1:0] vec);
        int unsigned ones;
        ones = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (vec[i]) begin
                ones++;
            end
        end
        return (ones == 1);
    endfunction

    // For a legal one-hot input this is the position of the set bit. For an
    // illegal input the result is meaningless; callers qualify with is_one_hot.
    function automatic logic [MAX_IDX_W-1:0] one_hot_to_idx(input logic [MAX_CH-1:0] vec);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (vec[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// rtl/skid_fifo2.sv - two-entry beat buffer for one output channel of the demux
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push_valid    beat offered by the distributor
//   push_ready    buffer not full (registered, independent of pop_ready)
//   push_pld      payload of the offered beat
//   pop_valid     buffer holds at least one beat
//   pop_ready     consumer accepts the head beat
//   pop_pld       payload of the head beat

module skid_fifo2 #(
    parameter int PLD_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [PLD_W-1:0] push_pld,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [PLD_W-1:0] pop_pld
);

    logic [PLD_W-1:0] entry [2];
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic             head;
    logic             full;
    logic             push;
    logic             pop;
    logic             wr_ptr;

    // Full is a registered copy of count == 2 so that the upstream ready has
    // no combinational path from the consumer's pop_ready. The price is that
    // a full buffer refuses a push even in the cycle it pops.
    assign push_ready = ~full;
    assign push       = push_valid & ~full;
    assign pop        = pop_valid & pop_ready;

    assign pop_valid  = (count != 2'd0);
    assign pop_pld    = entry[head];

    // A push only happens at count 0 or 1, so the free slot is head when
    // empty and the other entry when one beat is held.
    assign wr_ptr     = head ^ count[0];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= 2'd0;
            head     <= 1'b0;
            full     <= 1'b0;
            entry[0] <= '0;
            entry[1] <= '0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= push_pld;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count_next;
            full  <= (count_next == 2'd2);
        end
    end

endmodule

// File: rtl/one_hot_demux.sv
// rtl/one_hot_demux.sv - buffered 1-to-CH_N payload distributor with one-hot select
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_valid     input beat present
//   in_ready     input beat accepted when in_valid & in_ready
//   in_sel       one-hot destination channel, qualified by in_valid
//   in_pld       input payload
//   out_valid    per-channel beat present
//   out_ready    per-channel consumer accept
//   out_pld      per-channel payload, slice i belongs to channel i
//   err_sel      one-cycle pulse per dropped beat with an illegal select
//
// CH_N is limited to one_hot_pkg::MAX_CH.

module one_hot_demux #(
    parameter int CH_N  = 4,
    parameter int PLD_W = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH_N-1:0]       in_sel,
    input  logic [PLD_W-1:0]      in_pld,
    output logic [CH_N-1:0]       out_valid,
    input  logic [CH_N-1:0]       out_ready,
    output logic [CH_N*PLD_W-1:0] out_pld,
    output logic                  err_sel
);

    import one_hot_pkg::*;

    logic            legal;
    logic [CH_N-1:0] push_valid;
    logic [CH_N-1:0] push_ready;

    assign legal = is_one_hot(MAX_CH'(in_sel));

    // With a legal select exactly one bit of in_sel survives the AND, so the
    // reduction picks the destination's not-full flag. Illegal beats are
    // always swallowed so a bad decoder output can never wedge the source.
    assign in_ready   = legal ? |(in_sel & push_ready) : 1'b1;
    assign push_valid = {CH_N{in_valid & legal}} & in_sel;

    for (genvar g = 0; g < CH_N; g++) begin : g_ch
        skid_fifo2 #(
            .PLD_W (PLD_W)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push_valid (push_valid[g]),
            .push_ready (push_ready[g]),
            .push_pld   (in_pld),
            .pop_valid  (out_valid[g]),
            .pop_ready  (out_ready[g]),
            .pop_pld    (out_pld[g*PLD_W +: PLD_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sel <= 1'b0;
        end else begin
            err_sel <= in_valid & ~legal;
        end
    end

endmodule

// File: tb/tb_one_hot_demux.sv
// tb/tb_one_hot_demux.sv - scoreboard bench for one_hot_demux

module tb_one_hot_demux;

    localparam int CH_N  = 4;
    localparam int PLD_W = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [CH_N-1:0]       in_sel = '0;
    logic [PLD_W-1:0]      in_pld = '0;
    logic [CH_N-1:0]       out_valid;
    logic [CH_N-1:0]       out_ready = '0;
    logic [CH_N*PLD_W-1:0] out_pld;
    logic                  err_sel;

    always #5 clk = ~clk;

    one_hot_demux #(
        .CH_N  (CH_N),
        .PLD_W (PLD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_pld    (in_pld),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pld   (out_pld),
        .err_sel   (err_sel)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: beats the block currently holds, per channel, oldest first.
    logic [PLD_W-1:0] exp_q [CH_N][$];
    int               popped [CH_N];
    logic             drop_prev = 1'b0;
    logic             mon_en = 1'b0;

    int               rec_d;
    int               rec_occ;
    logic             rec_legal;
    logic             rec_rdy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: compares what the DUT presents against the expected queues and
    // retires beats the consumer takes.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < CH_N; i++) begin
                check($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(exp_q[i].size() != 0));
                if (out_valid[i] && exp_q[i].size() != 0) begin
                    check($sformatf("out_pld[%0d]", i), 64'(out_pld[i*PLD_W +: PLD_W]), 64'(exp_q[i][0]));
                    if (out_ready[i]) begin
                        void'(exp_q[i].pop_front());
                        popped[i]++;
                    end
                end
            end
            check("err_sel", 64'(err_sel), 64'(drop_prev));
        end
    end

    // Recorder: decides from the select rules whether this cycle's beat is
    // taken and pushes it onto the expected queue for its channel.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            for (int i = 0; i < CH_N; i++) begin
                exp_q[i].delete();
                popped[i] = 0;
            end
            drop_prev = 1'b0;
        end else if (mon_en) begin
            rec_legal = ($countones(in_sel) == 1);
            rec_d = 0;
            for (int i = 0; i < CH_N; i++) begin
                if (in_sel[i]) rec_d = i;
            end
            rec_rdy = 1'b1;
            if (rec_legal) begin
                rec_occ = exp_q[rec_d].size() + popped[rec_d];
                rec_rdy = (rec_occ < 2);
            end
            check("in_ready", 64'(in_ready), 64'(rec_rdy));
            drop_prev = in_valid && !rec_legal;
            if (in_valid && rec_legal && rec_rdy) begin
                exp_q[rec_d].push_back(in_pld);
            end
            for (int i = 0; i < CH_N; i++) popped[i] = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat until taken; entered and left at posedge+1.
    task automatic send(input logic [CH_N-1:0] sel, input logic [PLD_W-1:0] pld, input bit must_ready);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_pld   = pld;
        @(negedge clk);
        if (must_ready) check("send_ready", 64'(in_ready), 64'd1);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: actual in_ready=0 required in_ready=1 within 50 cycles");
        end
        tick();
        in_valid = 1'b0;
    endtask

    logic [CH_N-1:0] sel_list [7];

    initial begin
        sel_list[0] = 4'b0001; sel_list[1] = 4'b0010; sel_list[2] = 4'b0100;
        sel_list[3] = 4'b1000; sel_list[4] = 4'b0000; sel_list[5] = 4'b0110;
        sel_list[6] = 4'b1111;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_pld", 64'(out_pld), 64'd0);
        check("rst_err_sel", 64'(err_sel), 64'd0);
        for (int k = 0; k < 7; k++) begin
            tick();
            in_sel = sel_list[k];
            @(negedge clk);
            check("rst_in_ready", 64'(in_ready), 64'd1);
        end
        tick();

        // Single beat
        out_ready = '0;
        send(4'b0100, 8'hA5, 1'b1);
        @(negedge clk);
        check("single_out_valid", 64'(out_valid), 64'(4'b0100));
        check("single_out_pld2", 64'(out_pld[23:16]), 64'hA5);
        tick();
        out_ready = '1;
        repeat (2) tick();

        // Fill and backpressure on channel 1
        out_ready = '0;
        send(4'b0010, 8'h01, 1'b1);
        send(4'b0010, 8'h02, 1'b1);
        in_valid = 1'b1;
        in_sel   = 4'b0010;
        in_pld   = 8'h03;
        @(negedge clk);
        check("full_ready_a", 64'(in_ready), 64'd0);
        tick();
        @(negedge clk);
        check("full_ready_b", 64'(in_ready), 64'd0);
        tick();
        out_ready = 4'b0010;
        @(negedge clk);
        check("full_ready_pop_cycle", 64'(in_ready), 64'd0);
        tick();
        @(negedge clk);
        check("full_ready_after_pop", 64'(in_ready), 64'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = '1;
        repeat (4) tick();

        // Streaming on channel 0
        out_ready = 4'b0001;
        for (int v = 0; v < 16; v++) send(4'b0001, 8'(v), 1'b1);
        repeat (3) tick();

        // Head-of-line isolation: channel 3 full and stalled
        out_ready = '0;
        send(4'b1000, 8'hC1, 1'b1);
        send(4'b1000, 8'hC2, 1'b1);
        out_ready = 4'b0011;
        for (int k = 0; k < 8; k++) send((k % 2 == 1) ? 4'b0010 : 4'b0001, 8'h40 + 8'(k), 1'b1);
        @(negedge clk);
        check("hol_ch3_held", 64'(out_valid[3]), 64'd1);
        tick();
        out_ready = '1;
        repeat (4) tick();

        // Illegal selects back to back
        out_ready = '0;
        in_valid  = 1'b1;
        in_sel    = 4'b0000;
        @(negedge clk);
        check("illegal_ready_a", 64'(in_ready), 64'd1);
        tick();
        in_sel = 4'b0110;
        @(negedge clk);
        check("illegal_ready_b", 64'(in_ready), 64'd1);
        check("err_first", 64'(err_sel), 64'd1);
        tick();
        in_valid = 1'b0;
        in_sel   = 4'b0000;
        @(negedge clk);
        check("err_second", 64'(err_sel), 64'd1);
        check("illegal_no_valid", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk);
        check("err_cleared", 64'(err_sel), 64'd0);
        tick();

        // Reset mid-stream
        out_ready = '0;
        send(4'b0001, 8'h11, 1'b1);
        send(4'b0001, 8'h12, 1'b1);
        send(4'b0100, 8'h21, 1'b1);
        send(4'b0100, 8'h22, 1'b1);
        @(negedge clk);
        check("pre_reset_valid", 64'(out_valid), 64'(4'b0101));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_pld", 64'(out_pld), 64'd0);
        tick();
        out_ready = '1;
        repeat (4) tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 7)       in_sel = 4'(1 << $urandom_range(0, CH_N - 1));
            else if (r == 7) in_sel = 4'b0000;
            else             in_sel = 4'($urandom_range(0, 15));
            in_valid  = ($urandom_range(0, 3) != 0);
            in_pld    = 8'($urandom);
            out_ready = 4'($urandom_range(0, 15));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = '1;
        repeat (5) tick();
        @(negedge clk);
        check("final_drained", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
